// File: rtl/stack_cmd_master.sv
// Initiator for the stack_8x8 command interface: one host request at a time, shadow depth tracking.
// Define STKM_PRECHECK_EN to reject overflowing pushes / underflowing pops locally.
module stack_cmd_master #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [1:0]       stk_cmd,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty,
    input  logic             stk_error,
    output logic [DW-1:0]    depth,
    output logic             sync_err
);

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpClr  = 2'd1;
    localparam logic [1:0] OpPush = 2'd2;
    localparam logic [1:0] OpPop  = 2'd3;

    localparam logic [DW-1:0] FullCnt = DW'(DEPTH);

    typedef enum logic [2:0] {StInit, StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             sync_err_q, sync_err_d;

    logic at_full, at_empty, reject;

    assign at_full  = (depth_q == FullCnt);
    assign at_empty = (depth_q == '0);

`ifdef STKM_PRECHECK_EN
    assign reject = ((req_op == OpPush) && at_full) || ((req_op == OpPop) && at_empty);
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        depth_d     = depth_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sync_err_d  = sync_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        stk_cmd     = OpNop;
        stk_data_in = '0;

        unique case (state_q)
            StInit: begin
                stk_cmd = OpClr;
                state_d = StIdle;
            end
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d       = req_op;
                    data_d     = req_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if (reject) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                stk_cmd     = op_q;
                stk_data_in = data_q;
                state_d     = StWait;
                // Depth holds on an op the stack will refuse, so it stays within 0..DEPTH.
                case (op_q)
                    OpClr: begin
                        depth_d    = '0;
                        sync_err_d = 1'b0;
                    end
                    OpPush: if (!at_full) depth_d = depth_q + 1'b1;
                    OpPop:  if (!at_empty) depth_d = depth_q - 1'b1;
                    default: ;
                endcase
            end
            StWait: begin
                if ((op_q == OpPop) && !stk_error) rsp_data_d = stk_data_out;
                if ((op_q == OpPush) || (op_q == OpPop)) rsp_err_d = stk_error;
                if ((stk_full != at_full) || (stk_empty != at_empty)) sync_err_d = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        // Keep the stack idle and the host port closed while reset is held.
        if (rst) begin
            stk_cmd     = OpNop;
            stk_data_in = '0;
            req_ready   = 1'b0;
            rsp_valid   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            op_q       <= OpNop;
            data_q     <= '0;
            depth_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            depth_q    <= depth_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign depth    = depth_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_stack_cmd_master.sv
// Bench for stack_cmd_master: behavioural stack_8x8 stub plus a queue-based reference of the host view.
module tb_stack_cmd_master;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int DW    = 4;

`ifdef STKM_PRECHECK_EN
    localparam bit PRECHECK = 1'b1;
`else
    localparam bit PRECHECK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'd0;
    logic [WIDTH-1:0] req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [1:0]       stk_cmd;
    logic [WIDTH-1:0] stk_data_in;
    logic [WIDTH-1:0] stk_data_out;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_error;
    logic [DW-1:0]    depth;
    logic             sync_err;

    always #5 clk = ~clk;

    stack_cmd_master #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .stk_cmd      (stk_cmd),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .stk_error    (stk_error),
        .depth        (depth),
        .sync_err     (sync_err)
    );

    // Stack stub: registered outputs, valid the cycle after the command edge.
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp = 0;
    logic [WIDTH-1:0] s_dout = '0;
    logic             s_err = 1'b0;
    logic             force_ne = 1'b0;
    int               n_push_seen = 0;

    assign stk_data_out = s_dout;
    assign stk_error    = s_err;
    assign stk_full     = (sp == DEPTH);
    assign stk_empty    = force_ne ? 1'b0 : (sp == 0);

    always @(posedge clk) begin
        case (stk_cmd)
            2'd1: begin
                sp    <= 0;
                s_err <= 1'b0;
            end
            2'd2: begin
                n_push_seen <= n_push_seen + 1;
                if (sp == DEPTH) begin
                    s_err <= 1'b1;
                end else begin
                    mem[sp] <= stk_data_in;
                    s_dout  <= stk_data_in;
                    sp      <= sp + 1;
                    s_err   <= 1'b0;
                end
            end
            2'd3: begin
                if (sp == 0) begin
                    s_err <= 1'b1;
                end else begin
                    s_dout <= mem[sp-1];
                    sp     <= sp - 1;
                    s_err  <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference view of the host interface.
    logic [WIDTH-1:0] ref_q[$];
    bit               exp_sync = 1'b0;
    int               exp_push = 0;

    task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] d, input int hold);
        logic [WIDTH-1:0] e_data;
        logic             e_err;
        bit               rej;
        int               w;
        int               lat;
        e_data = '0;
        e_err  = 1'b0;
        rej    = 1'b0;
        case (op)
            2'd1: begin
                ref_q.delete();
                exp_sync = 1'b0;
            end
            2'd2: begin
                if (ref_q.size() == DEPTH) begin
                    e_err = 1'b1;
                    rej   = PRECHECK;
                end else begin
                    ref_q.push_back(d);
                end
                if (!rej) exp_push++;
            end
            2'd3: begin
                if (ref_q.size() == 0) begin
                    e_err = 1'b1;
                    rej   = PRECHECK;
                end else begin
                    e_data = ref_q.pop_back();
                end
            end
            default: ;
        endcase
        if (force_ne && !rej && ref_q.size() == 0) exp_sync = 1'b1;

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready_before_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, rej ? 1 : 3);
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_data", rsp_data, e_data);
        check_eq("rsp_err", rsp_err, e_err);
        check_eq("depth", depth, ref_q.size());
        check_eq("sync_err", sync_err, exp_sync);
        check_eq("req_ready_busy", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", rsp_valid, 1);
            check_eq("hold_rsp_data", rsp_data, e_data);
            check_eq("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", rsp_valid, 0);
        check_eq("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        int w;
        // Reset behaviour and the single INIT clear.
        repeat (2) @(negedge clk);
        check_eq("rst_stk_cmd", stk_cmd, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_depth", depth, 0);
        check_eq("rst_sync_err", sync_err, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        #1;
        check_eq("init_clr", stk_cmd, 1);
        @(negedge clk);
        check_eq("idle_stk_cmd", stk_cmd, 0);
        check_eq("idle_req_ready", req_ready, 1);
        check_eq("idle_depth", depth, 0);

        do_op(2'd2, 8'h01, 0);
        do_op(2'd2, 8'h02, 0);
        do_op(2'd3, 8'h00, 0);
        do_op(2'd1, 8'h00, 0);

        // Overfill by one.
        for (int i = 3; i <= 11; i++) do_op(2'd2, 8'(i), 0);
        check_eq("push_cmds_after_overfill", n_push_seen, exp_push);

        do_op(2'd1, 8'h00, 0);
        do_op(2'd3, 8'h00, 0);

        do_op(2'd2, 8'h55, 5);
        do_op(2'd1, 8'h00, 0);

        // Disagreeing empty flag during a NOP at depth 0.
        force_ne = 1'b1;
        do_op(2'd0, 8'h77, 0);
        force_ne = 1'b0;
        do_op(2'd1, 8'h00, 0);

        // Reset while a pop sits in WAIT.
        do_op(2'd2, 8'hA1, 0);
        do_op(2'd2, 8'hA2, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd3;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_req_ready", req_ready, 0);
        check_eq("midrst_depth", depth, 0);
        rst = 1'b0;
        #1;
        check_eq("midrst_clr", stk_cmd, 1);
        check_eq("midrst_rsp_valid_init", rsp_valid, 0);
        @(negedge clk);
        check_eq("midrst_idle_ready", req_ready, 1);
        check_eq("midrst_idle_depth", depth, 0);
        ref_q.delete();
        exp_sync = 1'b0;

        repeat (200) begin
            r = $urandom_range(0, 19);
            if (r == 0)      do_op(2'd0, 8'($urandom), $urandom_range(0, 2));
            else if (r == 1) do_op(2'd1, 8'($urandom), $urandom_range(0, 2));
            else if (r < 11) do_op(2'd2, 8'($urandom), $urandom_range(0, 2));
            else             do_op(2'd3, 8'($urandom), $urandom_range(0, 2));
        end
        check_eq("push_cmds_total", n_push_seen, exp_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
